// File: rtl/const_mul_seq_pkg.sv
// Shared defaults, width derivation and FSM state type for the sequential
// constant-coefficient multiplier.
package const_mul_seq_pkg;

  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned NCOEF_DEF = 4;
  localparam int unsigned CW_DEF    = 4;

  function automatic int unsigned ow_calc(input int unsigned dw, input int unsigned cw);
    return dw + cw;
  endfunction

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/const_mul_seq_mul.sv
// Combinational unsigned DW x CW multiply, built as a shift-add over the
// coefficient bits.
module const_mul_seq_mul
  import const_mul_seq_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF,
  localparam int unsigned OW = ow_calc(DW, CW)
) (
  input  logic [DW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [OW-1:0] p
);

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      if (b[i]) begin
        p = p + (OW'(a) << i);
      end
    end
  end

endmodule

// File: rtl/const_mul_seq.sv
// Sequential multiplier: one accepted sample is multiplied by each of NCOEF
// captured coefficients in turn, one product per output handshake.
module const_mul_seq
  import const_mul_seq_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned NCOEF = NCOEF_DEF,
  parameter int unsigned CW    = CW_DEF,
  localparam int unsigned OW   = ow_calc(DW, CW),
  localparam int unsigned IW   = $clog2(NCOEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DW-1:0]       d,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCOEF*CW-1:0] coef,
  output logic [OW-1:0]       out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IW-1:0]       out_idx,
  output logic                out_last
);

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   d_h;
  logic [CW-1:0]   coef_h [NCOEF];
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_inc;
  logic            last_slot;
  logic            accept;
  logic            hs;
  logic [DW-1:0]   mul_a;
  logic [CW-1:0]   mul_b;
  logic [OW-1:0]   prod;

  assign last_slot = (idx == IW'(NCOEF - 1));
  assign idx_inc   = idx + IW'(1);
  assign accept    = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign out_idx   = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (out_ready && last_slot && !in_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready in RUN is combinational from out_ready so the last handshake
  // and the next acceptance can share a cycle.
  always_comb begin
    out_valid = (state == RUN);
    out_last  = (state == RUN) && last_slot;
    in_ready  = (state == IDLE) || ((state == RUN) && out_ready && last_slot);
  end

  // The single multiplier sees the live inputs on acceptance, otherwise the
  // held sample against the coefficient for the upcoming index.
  always_comb begin
    mul_a = d_h;
    mul_b = coef_h[idx_inc];
    if (accept) begin
      mul_a = d;
      mul_b = coef[CW-1:0];
    end
  end

  const_mul_seq_mul #(
    .DW(DW),
    .CW(CW)
  ) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(prod)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_h <= '0;
      idx <= '0;
      out <= '0;
      for (int unsigned i = 0; i < NCOEF; i++) begin
        coef_h[i] <= '0;
      end
    end else if (accept) begin
      d_h <= d;
      idx <= '0;
      out <= prod;
      for (int unsigned i = 0; i < NCOEF; i++) begin
        coef_h[i] <= coef[i*CW +: CW];
      end
    end else if (hs && !last_slot) begin
      idx <= idx_inc;
      out <= prod;
    end
  end

endmodule

// File: tb/tb_const_mul_seq.sv
// Scoreboard bench for const_mul_seq: default configuration plus a wide
// DW=16/NCOEF=2/CW=8 instance.
module tb_const_mul_seq;

  typedef struct packed {
    logic [23:0] v;
    logic [3:0]  i;
    logic        l;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  d;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] coef;
  logic [11:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_idx;
  logic        out_last;

  logic [15:0] d2;
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] coef2;
  logic [23:0] out2;
  logic        out_valid2;
  logic        out_ready2;
  logic [0:0]  out_idx2;
  logic        out_last2;

  exp_t q[$];
  exp_t q2[$];
  exp_t me;
  exp_t me2;
  int   total = 0;
  int   bad   = 0;

  const_mul_seq #(.DW(8), .NCOEF(4), .CW(4)) u_dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .coef(coef), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last)
  );

  const_mul_seq #(.DW(16), .NCOEF(2), .CW(8)) u_dut2 (
    .clk(clk), .rst(rst), .d(d2), .in_valid(in_valid2), .in_ready(in_ready2),
    .coef(coef2), .out(out2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_idx(out_idx2), .out_last(out_last2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push4(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] c, input logic [23:0] e);
    q.push_back(exp_t'{v: a, i: 4'd0, l: 1'b0});
    q.push_back(exp_t'{v: b, i: 4'd1, l: 1'b0});
    q.push_back(exp_t'{v: c, i: 4'd2, l: 1'b0});
    q.push_back(exp_t'{v: e, i: 4'd3, l: 1'b1});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] dv);
    int n;
    d        = dv;
    in_valid = 1'b1;
    n        = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%0d want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((out_valid || q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, (n < 100), 1);
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0d want none", out);
      end else begin
        me = q.pop_front();
        chk("out", out, me.v);
        chk("out_idx", out_idx, me.i);
        chk("out_last", out_last, me.l);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid2 && out_ready2) begin
      if (q2.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out2: got %0d want none", out2);
      end else begin
        me2 = q2.pop_front();
        chk("out2", out2, me2.v);
        chk("out_idx2", out_idx2, me2.i);
        chk("out_last2", out_last2, me2.l);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk        = 1'b0;
    rst        = 1'b0;
    d          = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    coef       = {4'd8, 4'd7, 4'd3, 4'd1};
    d2         = '0;
    in_valid2  = 1'b0;
    out_ready2 = 1'b1;
    coef2      = {8'd255, 8'd255};

    #3;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out2", out2, 0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // basic sequence
    push4(255, 765, 1785, 2040);
    send(8'hFF);
    wait_idle("basic_drain");

    // back-to-back with in_valid held
    push4(2, 6, 14, 16);
    push4(5, 15, 35, 40);
    d        = 8'd2;
    in_valid = 1'b1;
    #1;
    chk("b2b_in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1;
    d = 8'd5;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_out_valid", out_valid, 1);
      chk("b2b_in_ready", in_ready, (i % 4 == 3));
      @(posedge clk);
      #1;
      if (i == 3) in_valid = 1'b0;
    end
    wait_idle("b2b_drain");

    // backpressure at idx 1
    push4(255, 765, 1785, 2040);
    send(8'hFF);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_out", out, 765);
      chk("stall_idx", out_idx, 1);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    wait_idle("stall_drain");

    // coefficient change after acceptance
    push4(255, 765, 1785, 2040);
    send(8'hFF);
    coef = '0;
    push4(0, 0, 0, 0);
    send(8'd9);
    wait_idle("coef_drain");
    coef = {4'd8, 4'd7, 4'd3, 4'd1};

    // reset mid-run at idx 2
    push4(255, 765, 1785, 2040);
    send(8'hFF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("midrst_idx_before", out_idx, 2);
    rst = 1'b0;
    #1;
    chk("midrst_out", out, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_idx", out_idx, 0);
    chk("midrst_pending", q.size(), 2);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid_rel", out_valid, 0);
    push4(1, 3, 7, 8);
    send(8'd1);
    wait_idle("midrst_drain");

    // wide configuration
    q2.push_back(exp_t'{v: 24'd16711425, i: 4'd0, l: 1'b0});
    q2.push_back(exp_t'{v: 24'd16711425, i: 4'd1, l: 1'b1});
    d2        = 16'hFFFF;
    in_valid2 = 1'b1;
    #1;
    chk("wide_in_ready", in_ready2, 1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    for (int n = 0; n < 100 && (out_valid2 || q2.size() != 0); n++) begin
      @(posedge clk);
      #1;
    end
    chk("wide_drain", (out_valid2 || q2.size() != 0), 0);

    chk("queue_empty", q.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/const_mul_seq.md
CONST_MUL_SEQ -- requirements
Module: const_mul_seq

Interface
REQ-001 Parameter DW, default 8, input sample width in bits.
REQ-002 Parameter NCOEF, default 4, coefficients per sequence; legal range 2..16.
REQ-003 Parameter CW, default 4, coefficient width in bits; output width OW = DW+CW.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d  input  DW  unsigned sample.
REQ-007 in_valid  input  1  d is valid this cycle.
REQ-008 in_ready  output  1  block accepts d this cycle.
REQ-009 coef  input  NCOEF*CW  unsigned coefficients; coef[i] occupies bits [i*CW +: CW].
REQ-010 out  output  OW  product of the held sample and the current coefficient.
REQ-011 out_valid  output  1  out, out_idx and out_last are valid.
REQ-012 out_ready  input  1  downstream accepts out this cycle.
REQ-013 out_idx  output  clog2(NCOEF)  coefficient index of the current out.
REQ-014 out_last  output  1  out_idx == NCOEF-1 while out_valid.

Function
REQ-015 FSM states are IDLE and RUN only.
REQ-016 An input is accepted in any cycle where in_valid && in_ready.
REQ-017 On acceptance, d and all of coef are captured into holding registers.
REQ-018 Coefficient changes after acceptance are ignored until the next acceptance.
REQ-019 In IDLE, in_ready = 1.
REQ-020 In RUN, in_ready = out_valid && out_ready && out_last, a combinational path from out_ready.
REQ-021 Out of IDLE, acceptance at edge k gives RUN, out_valid=1, out_idx=0 and out = d*coef[0] after edge k.
REQ-022 Each out handshake (out_valid && out_ready) increments out_idx by 1 and updates out = held_d*coef[out_idx].
REQ-023 When out_valid && !out_ready, out, out_idx and out_last are held unchanged (stall).
REQ-024 If the handshake on out_last coincides with a new acceptance, the next cycle presents out_idx=0 of the new sample, with no bubble.
REQ-025 If the handshake on out_last has no new acceptance, the FSM returns to IDLE and out_valid drops to 0 next cycle; out keeps its last value.
REQ-026 Products are unsigned and exactly OW bits wide; no overflow or truncation is possible.
REQ-027 A coefficient of 0 produces out=0 with out_valid=1; the slot is not skipped.
REQ-028 out_idx wraps from NCOEF-1 to 0 only through a new acceptance.
REQ-029 Throughput: one sample per NCOEF cycles when out_ready is held at 1.

Reset
REQ-030 While rst=0: state=IDLE, out=0, out_valid=0, out_idx=0, out_last=0, and held sample and coefficients = 0.
REQ-031 Reset asserted mid-sequence discards the in-flight sample; no partial sequence resumes.
REQ-032 In the first cycle after reset release, in_ready=1 and out_valid=0.

Structure
REQ-033 Package const_mul_seq_pkg holds the DW/NCOEF/CW defaults, the OW derivation function and the state enum {IDLE, RUN}.
REQ-034 Sub-module const_mul_seq_mul is a combinational unsigned DW x CW multiply built as a shift-add over the CW coefficient bits.
REQ-035 A single instance of const_mul_seq_mul is shared across all indices; muxing selects the held coefficient by index.

Verification
REQ-036 Basic sequence: DW=8, NCOEF=4, CW=4, coef={8,7,3,1} (idx3..0), d=0xFF accepted, out_ready=1 -> out = 255, 765, 1785, 2040 on consecutive cycles, out_last on the 4th.
REQ-037 Back-to-back: in_valid held with d=2 then d=5 -> outputs 2,6,14,16,5,15,35,40 with no gap; in_ready pulses only on the out_last cycles.
REQ-038 Backpressure: out_ready=0 for 3 cycles at idx=1 -> out=765 and idx=1 held throughout; sequence completes unchanged afterwards.
REQ-039 Coefficient change: coef altered to all-0 after acceptance -> current sequence uses the old values; next sample yields out=0 x4 with out_valid=1.
REQ-040 Reset mid-run: rst=0 at idx=2 -> out=0 and out_valid=0 immediately; after release in_ready=1 and a new d=1 yields 1,3,7,8.
REQ-041 Parameter sweep: DW=16, NCOEF=2, CW=8, coef={255,255}, d=0xFFFF -> out=16711425 (24-bit) twice.
